// File: rtl/chroma_key_pkg.sv
// Shared constants, pattern encodings and reset defaults for the chroma keyer.
package chroma_key_pkg;

    localparam int HUE_MOD        = 360;
    localparam int ANTI_DIAG_BIAS = 2160;
    localparam int SUM_W          = 13;
    localparam int BG_W           = 9;

    typedef enum logic [1:0] {
        BG_DIAG = 2'd0,
        BG_ANTI = 2'd1,
        BG_ROW  = 2'd2,
        BG_COL  = 2'd3
    } bg_sel_e;

    localparam int HUE_LO_RST  = 90;
    localparam int HUE_HI_RST  = 150;
    localparam int SAT_MIN_RST = 0;

endpackage

// File: rtl/chroma_key_if.sv
// Pixel stream bundle: qualified input beat plus delay-matched output beat.
interface chroma_key_if #(
    parameter int COORD_W = 11,
    parameter int PIX_W   = 24
);
    logic               in_valid;
    logic               in_sof;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [PIX_W-1:0]   pixel_in;
    logic [PIX_W-1:0]   pass_in;
    logic               out_valid;
    logic               out_sof;
    logic               out_keyed;
    logic [PIX_W-1:0]   pixel_out;
    logic [PIX_W-1:0]   pass_thru;

    modport master (
        output in_valid, in_sof, row, col, pixel_in, pass_in,
        input  out_valid, out_sof, out_keyed, pixel_out, pass_thru
    );

    modport slave (
        input  in_valid, in_sof, row, col, pixel_in, pass_in,
        output out_valid, out_sof, out_keyed, pixel_out, pass_thru
    );
endinterface

// File: rtl/hue_wrap360.sv
// Combinational x mod 360 for x < 5760 using a binary subtract ladder.
module hue_wrap360
    import chroma_key_pkg::*;
(
    input  logic [SUM_W-1:0] x,
    output logic [BG_W-1:0]  y
);
    logic [SUM_W-1:0] s0, s1, s2, s3;

    always_comb begin
        s0 = (x  >= SUM_W'(8 * HUE_MOD)) ? x  - SUM_W'(8 * HUE_MOD) : x;
        s1 = (s0 >= SUM_W'(4 * HUE_MOD)) ? s0 - SUM_W'(4 * HUE_MOD) : s0;
        s2 = (s1 >= SUM_W'(2 * HUE_MOD)) ? s1 - SUM_W'(2 * HUE_MOD) : s1;
        s3 = (s2 >= SUM_W'(HUE_MOD))     ? s2 - SUM_W'(HUE_MOD)     : s2;
        y  = BG_W'(s3);
    end
endmodule

// File: rtl/chroma_key_pipe.sv
// Chroma keyer: 3-stage pipeline replacing in-window, saturated pixels with a
// scrolling hue-pattern background; configuration is shadowed at start-of-frame.
module chroma_key_pipe #(
    parameter int COORD_W = 11,
    parameter int HUE_W   = 9,
    parameter int SAT_W   = 7,
    parameter int PIX_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gsc_en,
    input  logic [1:0]       bg_sel,
    input  logic [HUE_W-1:0] hue_lo,
    input  logic [HUE_W-1:0] hue_hi,
    input  logic [SAT_W-1:0] sat_min,
    input  logic             scroll_en,
    chroma_key_if.slave      vid
);
    import chroma_key_pkg::*;

    logic [COORD_W-1:0] row_in, col_in;
    logic [SUM_W-1:0]   row_x, col_x, off_x;
    logic               sof_acc;

    logic [BG_W-1:0]  off_q, off_d;
    logic             gsc_en_q, gsc_en_d;
    bg_sel_e          bg_sel_q, bg_sel_d;
    logic [HUE_W-1:0] hue_lo_q, hue_lo_d, hue_hi_q, hue_hi_d;
    logic [SAT_W-1:0] sat_min_q, sat_min_d;

    logic             valid1_q, valid1_d, sof1_q, sof1_d;
    logic [PIX_W-1:0] pix1_q, pix1_d, pass1_q, pass1_d;
    logic [SUM_W-1:0] sum_q [4];
    logic [SUM_W-1:0] sum_d [4];
    logic [BG_W-1:0]  wrap [4];

    logic [HUE_W-1:0] hue1;
    logic [SAT_W-1:0] sat1;
    logic             in_window, in_range;
    logic [BG_W-1:0]  bg_pick;
    logic             valid2_q, valid2_d, sof2_q, sof2_d, key2_q, key2_d;
    logic [PIX_W-1:0] pix2_q, pix2_d, pass2_q, pass2_d;
    logic [BG_W-1:0]  bg2_q, bg2_d;

    logic [HUE_W-1:0] bg_ext;
    logic             valid3_q, valid3_d, sof3_q, sof3_d, key3_q, key3_d;
    logic [PIX_W-1:0] pix3_q, pix3_d, pass3_q, pass3_d;

    assign row_in = vid.row;
    assign col_in = vid.col;
    assign row_x  = SUM_W'(row_in);
    assign col_x  = SUM_W'(col_in);

    // The SOF pixel itself must see the freshly loaded config and offset.
    always_comb begin
        sof_acc   = vid.in_valid & vid.in_sof;
        off_d     = off_q;
        gsc_en_d  = gsc_en_q;
        bg_sel_d  = bg_sel_q;
        hue_lo_d  = hue_lo_q;
        hue_hi_d  = hue_hi_q;
        sat_min_d = sat_min_q;
        if (sof_acc) begin
            gsc_en_d  = gsc_en;
            bg_sel_d  = bg_sel_e'(bg_sel);
            hue_lo_d  = hue_lo;
            hue_hi_d  = hue_hi;
            sat_min_d = sat_min;
            if (scroll_en) begin
                off_d = (off_q == BG_W'(HUE_MOD - 1)) ? '0 : off_q + 1'b1;
            end
        end
        off_x    = SUM_W'(off_d);
        valid1_d = vid.in_valid;
        sof1_d   = sof_acc;
        pix1_d   = pix1_q;
        pass1_d  = pass1_q;
        sum_d    = sum_q;
        if (vid.in_valid) begin
            pix1_d   = vid.pixel_in;
            pass1_d  = vid.pass_in;
            sum_d[0] = row_x + col_x + off_x;
            sum_d[1] = row_x + (SUM_W'(ANTI_DIAG_BIAS) - col_x) + off_x;
            sum_d[2] = row_x + off_x;
            sum_d[3] = col_x + off_x;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_wrap
        hue_wrap360 u_wrap (
            .x (sum_q[g]),
            .y (wrap[g])
        );
    end

    always_comb begin
        hue1 = pix1_q[PIX_W-1 -: HUE_W];
        sat1 = pix1_q[PIX_W-HUE_W-1 -: SAT_W];
        if (hue_lo_q <= hue_hi_q) begin
            in_window = (hue1 >= hue_lo_q) && (hue1 <= hue_hi_q);
        end else begin
            in_window = (hue1 >= hue_lo_q) || (hue1 <= hue_hi_q);
        end
        in_range = in_window && (hue1 < HUE_W'(HUE_MOD));
        case (bg_sel_q)
            BG_DIAG: bg_pick = wrap[0];
            BG_ANTI: bg_pick = wrap[1];
            BG_ROW:  bg_pick = wrap[2];
            default: bg_pick = wrap[3];
        endcase
        valid2_d = valid1_q;
        sof2_d   = sof1_q;
        pix2_d   = pix2_q;
        pass2_d  = pass2_q;
        bg2_d    = bg2_q;
        key2_d   = key2_q;
        if (valid1_q) begin
            pix2_d  = pix1_q;
            pass2_d = pass1_q;
            bg2_d   = bg_pick;
            key2_d  = gsc_en_q && in_range && (sat1 >= sat_min_q);
        end
    end

    assign bg_ext = HUE_W'(bg2_q);

    always_comb begin
        valid3_d = valid2_q;
        sof3_d   = sof2_q;
        pix3_d   = pix3_q;
        pass3_d  = pass3_q;
        key3_d   = key3_q;
        if (valid2_q) begin
            pass3_d = pass2_q;
            key3_d  = key2_q;
            pix3_d  = key2_q ? {bg_ext, {(PIX_W-HUE_W){1'b1}}} : pix2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            off_q     <= '0;
            gsc_en_q  <= 1'b0;
            bg_sel_q  <= BG_DIAG;
            hue_lo_q  <= HUE_W'(HUE_LO_RST);
            hue_hi_q  <= HUE_W'(HUE_HI_RST);
            sat_min_q <= SAT_W'(SAT_MIN_RST);
            valid1_q  <= 1'b0;
            sof1_q    <= 1'b0;
            pix1_q    <= '0;
            pass1_q   <= '0;
            sum_q     <= '{default: '0};
            valid2_q  <= 1'b0;
            sof2_q    <= 1'b0;
            pix2_q    <= '0;
            pass2_q   <= '0;
            bg2_q     <= '0;
            key2_q    <= 1'b0;
            valid3_q  <= 1'b0;
            sof3_q    <= 1'b0;
            pix3_q    <= '0;
            pass3_q   <= '0;
            key3_q    <= 1'b0;
        end else begin
            off_q     <= off_d;
            gsc_en_q  <= gsc_en_d;
            bg_sel_q  <= bg_sel_d;
            hue_lo_q  <= hue_lo_d;
            hue_hi_q  <= hue_hi_d;
            sat_min_q <= sat_min_d;
            valid1_q  <= valid1_d;
            sof1_q    <= sof1_d;
            pix1_q    <= pix1_d;
            pass1_q   <= pass1_d;
            sum_q     <= sum_d;
            valid2_q  <= valid2_d;
            sof2_q    <= sof2_d;
            pix2_q    <= pix2_d;
            pass2_q   <= pass2_d;
            bg2_q     <= bg2_d;
            key2_q    <= key2_d;
            valid3_q  <= valid3_d;
            sof3_q    <= sof3_d;
            pix3_q    <= pix3_d;
            pass3_q   <= pass3_d;
            key3_q    <= key3_d;
        end
    end

    assign vid.out_valid = valid3_q;
    assign vid.out_sof   = sof3_q;
    assign vid.out_keyed = key3_q;
    assign vid.pixel_out = pix3_q;
    assign vid.pass_thru = pass3_q;
endmodule

// File: tb/tb_chroma_key_pipe.sv
// Directed bench for chroma_key_pipe with hand-computed backgrounds and keys.
module tb_chroma_key_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       gsc_en;
    logic [1:0] bg_sel;
    logic [8:0] hue_lo;
    logic [8:0] hue_hi;
    logic [6:0] sat_min;
    logic       scroll_en;

    int compared   = 0;
    int mismatched = 0;

    chroma_key_if #(.COORD_W(11), .PIX_W(24)) vid ();

    chroma_key_pipe #(
        .COORD_W (11),
        .HUE_W   (9),
        .SAT_W   (7),
        .PIX_W   (24)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .gsc_en    (gsc_en),
        .bg_sel    (bg_sel),
        .hue_lo    (hue_lo),
        .hue_hi    (hue_hi),
        .sat_min   (sat_min),
        .scroll_en (scroll_en),
        .vid       (vid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] mk_pix(input int h, input int s, input int r);
        logic [8:0] hh;
        logic [6:0] ss;
        logic [7:0] rr;
        hh = h[8:0];
        ss = s[6:0];
        rr = r[7:0];
        return {hh, ss, rr};
    endfunction

    function automatic logic [23:0] keyed_pix(input int bg);
        logic [8:0] bb;
        bb = bg[8:0];
        return {bb, 15'h7FFF};
    endfunction

    task automatic applyStimulus(input logic sof, input int r, input int c,
                                 input logic [23:0] pix, input logic [23:0] pass);
        @(negedge clk);
        vid.in_valid = 1'b1;
        vid.in_sof   = sof;
        vid.row      = 11'(r);
        vid.col      = 11'(c);
        vid.pixel_in = pix;
        vid.pass_in  = pass;
    endtask

    task automatic idleCycle();
        @(negedge clk);
        vid.in_valid = 1'b0;
        vid.in_sof   = 1'b0;
    endtask

    task automatic expectBeat(input string tag, input logic [23:0] exp_pix, input logic exp_keyed,
                              input logic exp_sof, input logic [23:0] exp_pass);
        checkOutput({tag, ".valid"}, vid.out_valid, 1);
        checkOutput({tag, ".sof"},   vid.out_sof, exp_sof);
        checkOutput({tag, ".keyed"}, vid.out_keyed, exp_keyed);
        checkOutput({tag, ".pix"},   vid.pixel_out, exp_pix);
        checkOutput({tag, ".pass"},  vid.pass_thru, exp_pass);
    endtask

    // One isolated beat: output must be absent two cycles in and present at the third.
    task automatic runPixel(input string tag, input logic sof, input int r, input int c,
                            input logic [23:0] pix, input logic [23:0] pass,
                            input logic [23:0] exp_pix, input logic exp_keyed);
        applyStimulus(sof, r, c, pix, pass);
        idleCycle();
        idleCycle();
        checkOutput({tag, ".early"}, vid.out_valid, 0);
        @(negedge clk);
        expectBeat(tag, exp_pix, exp_keyed, sof, pass);
    endtask

    task automatic checkDefaults(input string tag);
        checkOutput({tag, ".gsc_en"},  dut.gsc_en_q, 0);
        checkOutput({tag, ".bg_sel"},  dut.bg_sel_q, 0);
        checkOutput({tag, ".hue_lo"},  dut.hue_lo_q, 90);
        checkOutput({tag, ".hue_hi"},  dut.hue_hi_q, 150);
        checkOutput({tag, ".sat_min"}, dut.sat_min_q, 0);
        checkOutput({tag, ".off"},     dut.off_q, 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".valid"}, vid.out_valid, 0);
        checkOutput({tag, ".sof"},   vid.out_sof, 0);
        checkOutput({tag, ".keyed"}, vid.out_keyed, 0);
        checkOutput({tag, ".pix"},   vid.pixel_out, 0);
        checkOutput({tag, ".pass"},  vid.pass_thru, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        rst_n        = 1'b0;
        gsc_en       = 1'b0;
        bg_sel       = 2'd0;
        hue_lo       = 9'd0;
        hue_hi       = 9'd0;
        sat_min      = 7'd0;
        scroll_en    = 1'b0;
        vid.in_valid = 1'b0;
        vid.in_sof   = 1'b0;
        vid.row      = '0;
        vid.col      = '0;
        vid.pixel_in = '0;
        vid.pass_in  = '0;

        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        checkDefaults("reset");
        rst_n = 1'b1;

        gsc_en = 1'b1; bg_sel = 2'd0; hue_lo = 9'd90; hue_hi = 9'd150; sat_min = 7'd0;
        runPixel("key_basic", 1'b1, 10, 20, mk_pix(120, 0, 0), 24'hABCDEF, keyed_pix(30), 1'b1);

        gsc_en = 1'b0;
        runPixel("gsc_off", 1'b1, 10, 20, mk_pix(120, 0, 8'h5A), 24'hABCDEF, mk_pix(120, 0, 8'h5A), 1'b0);

        gsc_en = 1'b1;
        runPixel("win_lo",   1'b1, 10, 20, mk_pix(90, 1, 1),  24'h000001, keyed_pix(30), 1'b1);
        runPixel("win_hi",   1'b0, 10, 20, mk_pix(150, 1, 2), 24'h000002, keyed_pix(30), 1'b1);
        runPixel("win_blo",  1'b0, 10, 20, mk_pix(89, 1, 3),  24'h000003, mk_pix(89, 1, 3), 1'b0);
        runPixel("win_bhi",  1'b0, 10, 20, mk_pix(151, 1, 4), 24'h000004, mk_pix(151, 1, 4), 1'b0);

        sat_min = 7'd64;
        runPixel("sat_eq",   1'b1, 10, 20, mk_pix(120, 64, 5), 24'h000005, keyed_pix(30), 1'b1);
        runPixel("sat_lt",   1'b0, 10, 20, mk_pix(120, 63, 6), 24'h000006, mk_pix(120, 63, 6), 1'b0);
        sat_min = 7'd0;
        runPixel("sat_shad", 1'b0, 10, 20, mk_pix(120, 10, 7), 24'h000007, mk_pix(120, 10, 7), 1'b0);

        hue_lo = 9'd340; hue_hi = 9'd20;
        runPixel("wrap_350", 1'b1, 10, 20, mk_pix(350, 5, 8),  24'h000008, keyed_pix(30), 1'b1);
        runPixel("wrap_5",   1'b0, 10, 20, mk_pix(5, 5, 9),    24'h000009, keyed_pix(30), 1'b1);
        runPixel("wrap_20",  1'b0, 10, 20, mk_pix(20, 5, 10),  24'h00000A, keyed_pix(30), 1'b1);
        runPixel("wrap_30",  1'b0, 10, 20, mk_pix(30, 5, 11),  24'h00000B, mk_pix(30, 5, 11), 1'b0);
        runPixel("wrap_359", 1'b0, 10, 20, mk_pix(359, 5, 12), 24'h00000C, keyed_pix(30), 1'b1);
        runPixel("wrap_400", 1'b0, 10, 20, mk_pix(400, 5, 13), 24'h00000D, mk_pix(400, 5, 13), 1'b0);
        runPixel("wrap_339", 1'b0, 10, 20, mk_pix(339, 5, 14), 24'h00000E, mk_pix(339, 5, 14), 1'b0);

        hue_lo = 9'd90; hue_hi = 9'd150;
        bg_sel = 2'd0;
        runPixel("bg_diag",  1'b1, 5, 700, mk_pix(120, 5, 0), 24'h000010, keyed_pix(345), 1'b1);
        bg_sel = 2'd1;
        runPixel("bg_nosof", 1'b0, 5, 700, mk_pix(120, 5, 0), 24'h000011, keyed_pix(345), 1'b1);
        runPixel("bg_anti",  1'b1, 5, 700, mk_pix(120, 5, 0), 24'h000012, keyed_pix(25), 1'b1);
        bg_sel = 2'd3;
        runPixel("bg_col",   1'b1, 5, 700, mk_pix(120, 5, 0), 24'h000013, keyed_pix(340), 1'b1);
        bg_sel = 2'd2;
        runPixel("bg_row",   1'b1, 5, 700, mk_pix(120, 5, 0), 24'h000014, keyed_pix(5), 1'b1);
        bg_sel = 2'd0;
        runPixel("bg_dmax",  1'b1, 2047, 2047, mk_pix(120, 5, 0), 24'h000015, keyed_pix(134), 1'b1);
        bg_sel = 2'd1;
        runPixel("bg_amax",  1'b1, 2047, 0, mk_pix(120, 5, 0), 24'h000016, keyed_pix(247), 1'b1);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gsc_en = 1'b1; bg_sel = 2'd2; hue_lo = 9'd90; hue_hi = 9'd150; sat_min = 7'd0; scroll_en = 1'b1;
        for (int i = 0; i < 364; i++) begin
            @(negedge clk);
            if (i >= 3) begin
                e = (i - 2) % 360;
                checkOutput($sformatf("scroll[%0d].valid", i - 3), vid.out_valid, 1);
                checkOutput($sformatf("scroll[%0d].pix", i - 3), vid.pixel_out, keyed_pix(e));
            end
            if (i < 361) begin
                vid.in_valid = 1'b1;
                vid.in_sof   = 1'b1;
                vid.row      = '0;
                vid.col      = 11'(i);
                vid.pixel_in = mk_pix(120, 3, 0);
                vid.pass_in  = 24'(i);
            end else begin
                vid.in_valid = 1'b0;
                vid.in_sof   = 1'b0;
            end
        end
        checkOutput("scroll.off_end", dut.off_q, 1);

        gsc_en = 1'b1; bg_sel = 2'd0; hue_lo = 9'd10; hue_hi = 9'd200; sat_min = 7'd5; scroll_en = 1'b1;
        applyStimulus(1'b1, 1, 1, mk_pix(120, 20, 1), 24'h111111);
        applyStimulus(1'b0, 2, 2, mk_pix(120, 20, 2), 24'h222222);
        applyStimulus(1'b0, 3, 3, mk_pix(120, 20, 3), 24'h333333);
        @(negedge clk);
        rst_n        = 1'b0;
        vid.in_valid = 1'b0;
        vid.in_sof   = 1'b0;
        checkOutput("midrst.inflight", vid.out_valid, 1);
        @(negedge clk);
        checkIdleOutputs("midrst");
        checkDefaults("midrst");
        @(negedge clk);
        checkOutput("midrst.hold", vid.out_valid, 0);
        rst_n = 1'b1;
        runPixel("post_rst", 1'b0, 4, 4, mk_pix(120, 20, 3), 24'h444444, mk_pix(120, 20, 3), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/chroma_key_pipe.md
# chroma_key_pipe

Pipelined, parametrised chroma keyer for the camera video path. Pixels whose hue lies inside a programmable (optionally wrap-around) window and whose saturation reaches a threshold are replaced with a procedurally generated hue-pattern background. Pattern geometry is selectable, and the pattern can scroll once per frame. Configuration is shadowed at start-of-frame, and a side-band pass channel is delay-matched to the pixel path.

## Interface
Parameters:
- COORD_W, 11: width of row/col; pattern math is correct for any coordinate up to 2^COORD_W-1 ≤ 2047
- HUE_W, 9: hue field width; pixel bits [PIX_W-1 -: HUE_W]
- SAT_W, 7: saturation field width; bits directly below hue
- PIX_W, 24: pixel and pass-channel width

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- gsc_en  in  1  keying enable (shadowed)
- bg_sel  in  2  pattern: 0 diag (row+col), 1 anti-diag (row−col), 2 row bands, 3 col bands (shadowed)
- hue_lo, hue_hi  in  HUE_W  key window bounds, inclusive (shadowed)
- sat_min  in  SAT_W  minimum saturation to key (shadowed)
- scroll_en  in  1  advance pattern offset each frame (sampled at SOF)
- in_valid  in  1  input pixel qualifier
- in_sof  in  1  first pixel of frame; meaningful only with in_valid
- row, col  in  COORD_W  pixel coordinates
- pixel_in  in  PIX_W  {hue, sat, rest}
- pass_in  in  PIX_W  side-band data
- out_valid, out_sof  out  1  delayed qualifiers
- pixel_out  out  PIX_W  keyed or original pixel
- out_keyed  out  1  this pixel was replaced
- pass_thru  out  PIX_W  pass_in, delayed to align with pixel_out

## Operation
- Shadow registers: gsc_en, bg_sel, hue_lo, hue_hi, sat_min load on the cycle with in_valid=1 and in_sof=1. That SOF pixel already uses the new values. Ports are ignored at all other times.
- Offset register `off` (0..359):
  - At an accepted SOF, off ← (off+1) mod 360 if scroll_en, else unchanged.
  - The SOF pixel uses the updated value.
- Pattern hue bg, mod 360:
  - Mode 0: row+col+off
  - Mode 1: row+(2160−col)+off (2160 = 6·360, keeps the sum non-negative)
  - Mode 2: row+off
  - Mode 3: col+off
  - Maximum intermediate value is 4566, so sums are 13 bits.
- Hue window:
  - hue_lo ≤ hue_hi: in = lo ≤ h ≤ hi.
  - Otherwise (wrap window): in = h ≥ lo or h ≤ hi.
  - h ≥ 360 is never in the window.
- key = gsc_en & in & (sat ≥ sat_min).
- Output:
  - key=1: pixel_out = {bg, all-ones in the remaining PIX_W−HUE_W bits}, out_keyed=1.
  - key=0: pixel_out = pixel_in, out_keyed=0.
- No back-pressure. Every input beat is accepted.
- Stage data registers load only when that stage's valid is 1; they hold otherwise. Valid bits advance every cycle.
- in_sof with in_valid=0: ignored (no shadow load, no offset change).

## Timing
- Fixed latency: 3 cycles from in_valid to out_valid.
  - S1 registers inputs, shadow config, offset and raw sums.
  - S2 performs mod 360 and the key decision.
  - S3 performs the output mux.
- pass_thru, out_sof, out_keyed are aligned with pixel_out on the same cycle.
- Reset values (rst_n=0 at an edge):
  - out_valid=0, out_sof=0, out_keyed=0
  - pixel_out=0, pass_thru=0, all stage registers=0
  - off=0
  - Shadow: gsc_en=0, bg_sel=0, hue_lo=90, hue_hi=150, sat_min=0
- Reset mid-frame: in-flight pixels are discarded, and out_valid is 0 from the following cycle until 3 cycles after the first post-reset in_valid.
- Back-to-back SOFs (1-pixel frames) are legal: each increments off.
- Throughput: 1 pixel/clk sustained.

## Structure
- Package chroma_key_pkg holds:
  - HUE_MOD=360 and ANTI_DIAG_BIAS=2160
  - BG_DIAG/BG_ANTI/BG_ROW/BG_COL encodings
  - reset defaults (90, 150, 0)
- Sub-module hue_wrap360: 13-bit in → 9-bit (x mod 360). Purely combinational, no multiply or divide (compare/subtract ladder of 2880, 1440, 720, 360). Four instances.

## Test plan
- Reset, then one pixel with hue=120, sat=0, gsc_en=1, bg_sel=0, row=10, col=20, scroll_en=0, SOF → after 3 cycles: pixel_out={9'd30,15'h7FFF}, out_keyed=1.
- Same stream with gsc_en=0 → pixel_out equals pixel_in after 3 cycles. pass_in=24'hABCDEF → pass_thru=24'hABCDEF on the same cycle.
- Wrap window hue_lo=340, hue_hi=20: hue 350 and 5 are keyed, hue 30 and 359 → 359 is keyed. hue 400 is not keyed.
- Change bg_sel mid-frame (no SOF) → no effect until the next SOF pixel. bg_sel=1, row=0, col=700 → bg=(2160−700) mod 360 = 20.
- scroll_en=1 over 361 SOFs, bg_sel=2, row=0 → bg sequence 1, 2, …, 359, 0, 1.
- Assert rst_n=0 with 3 pixels in flight → out_valid low from the next cycle, outputs 0, shadow registers at their defaults.
